// File: rtl/count_bus_checker.sv
// Receive-side checker for a free-running counter bus: synchronises the pad
// input, verifies hold/increment-by-one steps, locks after a good run and counts violations.
module count_bus_checker #(
    parameter int WIDTH      = 8,
    parameter int ERR_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             enable,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_seen,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] value
);

    localparam int ACQ_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(LOCK_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_TRACK   = 2'd2;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == ERR_MAX) ? c : c + ERR_W'(1);
    endfunction

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [1:0]       r_state;
    logic [ACQ_W-1:0] r_acq_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_err_seen;
    logic [ERR_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_delta;
    logic             w_valid;
    logic [1:0]       w_state_nxt;
    logic [ACQ_W-1:0] w_acq_nxt;
    logic             w_viol;

    // Modulo subtraction makes the all-ones -> zero wrap a plain +1 step.
    assign w_delta = r_sync2 - r_prev;
    assign w_valid = (w_delta == '0) || (w_delta == WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq_cnt;
        w_viol      = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_acq_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQUIRE;
                    w_acq_nxt   = '0;
                end
                S_ACQUIRE: begin
                    if (!w_valid) begin
                        w_acq_nxt = '0;
                    end else if (r_acq_cnt == ACQ_LAST) begin
                        w_state_nxt = S_TRACK;
                        w_acq_nxt   = '0;
                    end else begin
                        w_acq_nxt = r_acq_cnt + ACQ_W'(1);
                    end
                end
                S_TRACK: begin
                    if (!w_valid) begin
                        w_viol      = 1'b1;
                        w_state_nxt = S_ACQUIRE;
                        w_acq_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_acq_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_state     <= S_IDLE;
            r_acq_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_seen  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_sync1     <= bus_in;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_state     <= w_state_nxt;
            r_acq_cnt   <= w_acq_nxt;
            r_locked    <= (w_state_nxt == S_TRACK);
            r_err_pulse <= w_viol;
            // A violation outranks a simultaneous clear: it restarts the count at one.
            if (w_viol) begin
                r_err_seen  <= 1'b1;
                r_err_count <= clear ? ERR_W'(1) : sat_inc(r_err_count);
            end else if (clear) begin
                r_err_seen  <= 1'b0;
                r_err_count <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_seen  = r_err_seen;
    assign err_count = r_err_count;
    assign value     = r_prev;

endmodule

// File: doc/count_bus_checker.md
# count_bus_checker

Receive-side checker for a free-running counter bus driven onto pads by a peer chip's core. It synchronises the incoming bus, then confirms every sample either holds or increments by exactly one, with modulo-2^WIDTH wrap. It locks after a run of good samples and counts violations in a saturating counter. It sits in the core between the bidir/input pad inputs and the status outputs.

## Interface
- WIDTH, 8: width of the observed counter bus.
- ERR_W, 8: width of the error counter.
- LOCK_COUNT, 4: consecutive valid deltas required to lock; ≥1.

- clk  input  1  core clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- bus_in  input  WIDTH  counter value from pads, asynchronous to clk.
- enable  input  1  checker run enable.
- clear  input  1  clears err_count and err_seen.
- locked  output  1  high while in TRACK.
- err_pulse  output  1  one-cycle pulse per violation detected in TRACK.
- err_seen  output  1  sticky; set by any violation, cleared by clear or rst.
- err_count  output  ERR_W  saturating violation count.
- value  output  WIDTH  last synchronised sample (prev register).

## Operation
- Sync pipeline runs every cycle, independent of state and enable: sync1 <= bus_in, sync2 <= sync1, prev <= sync2. value = prev.
- delta = (sync2 - prev) mod 2^WIDTH. The sample is valid if delta is 0 (hold) or 1 (increment). 2^WIDTH-1 -> 0 is valid. Any other delta is a violation.
- States: IDLE, ACQUIRE, TRACK. The state register holds the current state; acq_cnt counts 0..LOCK_COUNT-1.
- IDLE: enable=1 -> ACQUIRE, acq_cnt=0. Otherwise stay.
- ACQUIRE, valid sample:
  - acq_cnt==LOCK_COUNT-1 -> TRACK, acq_cnt=0.
  - otherwise acq_cnt+1.
- ACQUIRE, violation: acq_cnt=0 and stay. Not counted as an error.
- TRACK, valid sample: stay.
- TRACK, violation: err_pulse=1 next cycle, err_seen=1, err_count+1 saturating at 2^ERR_W-1, go to ACQUIRE with acq_cnt=0.
- enable=0 in any state -> IDLE next cycle; acq_cnt=0. err_count and err_seen are kept.
- clear together with a TRACK violation: the violation wins. err_count=1, err_seen=1.
- clear alone: err_count=0, err_seen=0. State is unaffected.
- Counts saturate and never wrap.

## Timing
- Reset values: sync1, sync2, prev = 0; state = IDLE; acq_cnt = 0. locked, err_pulse, err_seen, err_count, value all 0.
- rst has priority over every other input.
- rst asserted mid-TRACK returns all outputs to their reset values after that edge.
- A bus_in value captured at edge k is on sync2 after edge k+1 and on prev/value after edge k+2.
- Evaluation of that sample (delta vs. previous) happens after edge k+1; its state, err_pulse and err_count updates appear after edge k+2.
- locked deasserts after the same edge that asserts err_pulse.
- From IDLE with enable rising before edge e, ACQUIRE is entered after e.
- With a continuously valid bus, locked asserts after edge e+LOCK_COUNT.
- The first ACQUIRE evaluation compares sync2 against prev; no priming cycle.
- err_pulse is high exactly one cycle per violation.
- Back-to-back violations in TRACK cannot occur, because the first one exits TRACK.
- All outputs are registered.

## Test plan
- Reset: hold rst 3 cycles with random bus_in -> locked=0, err_pulse=0, err_seen=0, err_count=0, value=0. The first value change appears no earlier than 3 edges after rst release.
- Lock with defaults (WIDTH=8, LOCK_COUNT=4): enable=1, bus_in counting 0,1,2… per cycle -> locked rises 4 edges after ACQUIRE entry. err_count stays 0.
- Wrap and hold: locked; bus_in 253,254,255,0,0,0,1 -> no err_pulse, locked stays 1.
- Jump: locked; bus_in 10 then 13 -> err_pulse for exactly 1 cycle, err_count=1, err_seen=1, locked=0. Resume 14,15,16,17 -> relock after 4 valid deltas.
- Saturation: ERR_W=2, LOCK_COUNT=1; inject 5 separated jumps, relocking between each -> err_count 1,2,3,3,3. Then clear -> err_count=0, err_seen=0.
- Corner events:
  - clear in the same cycle as a TRACK violation -> err_count=1.
  - enable=0 while locked -> locked=0 next cycle, err_count retained.
  - Jump while in ACQUIRE -> no err_pulse; acq_cnt restart delays lock by 4 more valid deltas.
